// File: rtl/axi_lite_xbar.sv
// One-master, two-slave AXI-lite crossbar with address decode and an internal DECERR responder.
// Exactly one transaction (read or write) is in flight at any time.
module axi_lite_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_0000,
    parameter logic [31:0] S1_MASK = 32'hFF00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_araddr,
    input  logic [31:0] m_awaddr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_arvalid,
    input  logic        m_rready,
    input  logic        m_awvalid,
    input  logic        m_wvalid,
    input  logic        m_bready,
    output logic        m_arready,
    output logic        m_rvalid,
    output logic        m_awready,
    output logic        m_wready,
    output logic        m_bvalid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic [1:0]  m_bresp,
    output logic [31:0] s_araddr,
    output logic [31:0] s_awaddr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic [1:0]  s_arvalid,
    output logic [1:0]  s_rready,
    output logic [1:0]  s_awvalid,
    output logic [1:0]  s_wvalid,
    output logic [1:0]  s_bready,
    input  logic [1:0]  s_arready,
    input  logic [1:0]  s_rvalid,
    input  logic [1:0]  s_awready,
    input  logic [1:0]  s_wready,
    input  logic [1:0]  s_bvalid,
    input  logic [63:0] s_rdata,
    input  logic [3:0]  s_rresp,
    input  logic [3:0]  s_bresp
);

    typedef enum logic [2:0] {IDLE, RD, WR, RD_ERR, WR_ERR} state_t;

    state_t      state, state_next;
    logic        sel;
    logic [31:0] addr_q;
    logic        ar_done, aw_done, w_done;

    logic [31:0] dec_addr;
    logic        dec_hit0, dec_hit1;
    logic        ar_hs, aw_hs, w_hs;

    // Reads win over writes when both arrive together, so decode the AR address first.
    assign dec_addr = m_arvalid ? m_araddr : m_awaddr;
    assign dec_hit0 = (dec_addr & S0_MASK) == S0_BASE;
    assign dec_hit1 = (dec_addr & S1_MASK) == S1_BASE;

    assign s_araddr = addr_q;
    assign s_awaddr = addr_q;

    assign ar_hs = m_arvalid & m_arready;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_rdata    = 32'h0;
        m_rresp    = 2'b00;
        m_bresp    = 2'b00;
        s_wdata    = 32'h0;
        s_wstrb    = 4'h0;
        s_arvalid  = 2'b00;
        s_rready   = 2'b00;
        s_awvalid  = 2'b00;
        s_wvalid   = 2'b00;
        s_bready   = 2'b00;

        case (state)
            IDLE: begin
                if (m_arvalid)
                    state_next = (dec_hit0 || dec_hit1) ? RD : RD_ERR;
                else if (m_awvalid)
                    state_next = (dec_hit0 || dec_hit1) ? WR : WR_ERR;
            end
            RD: begin
                s_arvalid[sel] = m_arvalid & ~ar_done;
                m_arready      = s_arready[sel] & ~ar_done;
                m_rvalid       = s_rvalid[sel];
                m_rdata        = sel ? s_rdata[63:32] : s_rdata[31:0];
                m_rresp        = sel ? s_rresp[3:2]   : s_rresp[1:0];
                s_rready[sel]  = m_rready;
                if (m_rvalid && m_rready)
                    state_next = IDLE;
            end
            WR: begin
                s_awvalid[sel] = m_awvalid & ~aw_done;
                m_awready      = s_awready[sel] & ~aw_done;
                s_wvalid[sel]  = m_wvalid & ~w_done;
                m_wready       = s_wready[sel] & ~w_done;
                s_wdata        = m_wdata;
                s_wstrb        = m_wstrb;
                // The response channel only opens once both address and data have been accepted.
                if (aw_done && w_done) begin
                    s_bready[sel] = m_bready;
                    m_bvalid      = s_bvalid[sel];
                    m_bresp       = sel ? s_bresp[3:2] : s_bresp[1:0];
                    if (m_bvalid && m_bready)
                        state_next = IDLE;
                end
            end
            RD_ERR: begin
                m_arready = ~ar_done;
                if (ar_done) begin
                    m_rvalid = 1'b1;
                    m_rresp  = 2'b11;
                    if (m_rready)
                        state_next = IDLE;
                end
            end
            WR_ERR: begin
                m_awready = ~aw_done;
                m_wready  = ~w_done;
                if (aw_done && w_done) begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                    if (m_bready)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            sel     <= 1'b0;
            addr_q  <= 32'h0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                addr_q <= dec_addr;
                sel    <= ~dec_hit0 & dec_hit1;
            end
            if (state_next == IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (ar_hs) ar_done <= 1'b1;
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: slave responses are driven by hand cycle by cycle.
// Inputs change 1ns after the rising edge; outputs are compared once they have settled.
module tb_axi_lite_xbar;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_araddr = '0, m_awaddr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        m_arvalid = 1'b0, m_rready = 1'b0, m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0;
    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [1:0]  s_arready = '0, s_rvalid = '0, s_awready = '0, s_wready = '0, s_bvalid = '0;
    logic [63:0] s_rdata = '0;
    logic [3:0]  s_rresp = '0, s_bresp = '0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    axi_lite_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_rready(m_rready), .m_awvalid(m_awvalid),
        .m_wvalid(m_wvalid), .m_bready(m_bready),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_awready(m_awready),
        .m_wready(m_wready), .m_bvalid(m_bvalid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
        .s_araddr(s_araddr), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arvalid(s_arvalid), .s_rready(s_rready), .s_awvalid(s_awvalid),
        .s_wvalid(s_wvalid), .s_bready(s_bready),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_awready(s_awready),
        .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_wdata = 32'h55;
        step();
        step();
        vecs++; if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 5'b0) begin errs++;
            $display("FAIL reset_m_hs got=%b exp=00000", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}); end
        vecs++; if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 10'b0) begin errs++;
            $display("FAIL reset_s_hs got=%b exp=0", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}); end
        vecs++; if (s_araddr !== 32'h0 || s_awaddr !== 32'h0) begin errs++;
            $display("FAIL reset_addr got=%h/%h exp=0", s_araddr, s_awaddr); end
        vecs++; if (s_wdata !== 32'h0) begin errs++;
            $display("FAIL reset_wdata got=%h exp=0", s_wdata); end
        rst = 1'b0;
        m_wdata = 32'h0;
    endtask

    task automatic test_read_s0();
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1; m_rready = 1'b1;
        #1;
        vecs++; if (s_arvalid !== 2'b00 || m_arready !== 1'b0) begin errs++;
            $display("FAIL rd0_idle_ar got s_arvalid=%b m_arready=%b exp 00/0", s_arvalid, m_arready); end
        step();
        vecs++; if (s_arvalid !== 2'b01) begin errs++;
            $display("FAIL rd0_s_arvalid got=%b exp=01", s_arvalid); end
        vecs++; if (s_araddr !== 32'h8000_0010) begin errs++;
            $display("FAIL rd0_araddr got=%h exp=80000010", s_araddr); end
        s_arready = 2'b01;
        #1;
        vecs++; if (m_arready !== 1'b1) begin errs++;
            $display("FAIL rd0_arready got=%b exp=1", m_arready); end
        step();
        m_arvalid = 1'b0; s_arready = 2'b00;
        #1;
        vecs++; if (s_arvalid !== 2'b00 || m_rvalid !== 1'b0) begin errs++;
            $display("FAIL rd0_wait got s_arvalid=%b m_rvalid=%b exp 00/0", s_arvalid, m_rvalid); end
        step();
        s_rvalid = 2'b01; s_rdata = {32'h1111_2222, 32'hDEAD_BEEF}; s_rresp = 4'b1100;
        #1;
        vecs++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || m_rresp !== 2'b00) begin errs++;
            $display("FAIL rd0_resp got v=%b d=%h r=%b exp 1/deadbeef/00", m_rvalid, m_rdata, m_rresp); end
        vecs++; if (s_rready !== 2'b01) begin errs++;
            $display("FAIL rd0_s_rready got=%b exp=01", s_rready); end
        step();
        s_rvalid = 2'b00; s_rresp = 4'b0;
        #1;
        vecs++; if (m_rvalid !== 1'b0 || s_rready !== 2'b00) begin errs++;
            $display("FAIL rd0_idle got m_rvalid=%b s_rready=%b exp 0/00", m_rvalid, s_rready); end
        m_rready = 1'b0;
    endtask

    task automatic test_write_w_first();
        m_wdata = 32'h41; m_wstrb = 4'b0001; m_wvalid = 1'b1; m_bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (m_wready !== 1'b0 || s_wvalid !== 2'b00) begin errs++;
                $display("FAIL wr1_w_held cyc%0d got m_wready=%b s_wvalid=%b exp 0/00", i, m_wready, s_wvalid); end
            step();
        end
        m_awaddr = 32'hA000_03F8; m_awvalid = 1'b1;
        #1;
        vecs++; if (s_awvalid !== 2'b00) begin errs++;
            $display("FAIL wr1_idle_aw got=%b exp=00", s_awvalid); end
        step();
        vecs++; if (s_awvalid !== 2'b10 || s_wvalid !== 2'b10) begin errs++;
            $display("FAIL wr1_valids got aw=%b w=%b exp 10/10", s_awvalid, s_wvalid); end
        vecs++; if (s_awaddr !== 32'hA000_03F8 || s_wdata !== 32'h41 || s_wstrb !== 4'b0001) begin errs++;
            $display("FAIL wr1_payload got a=%h d=%h s=%b exp a00003f8/41/0001", s_awaddr, s_wdata, s_wstrb); end
        s_awready = 2'b10; s_wready = 2'b10;
        #1;
        vecs++; if (m_awready !== 1'b1 || m_wready !== 1'b1) begin errs++;
            $display("FAIL wr1_readys got aw=%b w=%b exp 1/1", m_awready, m_wready); end
        step();
        m_awvalid = 1'b0; m_wvalid = 1'b0; s_awready = 2'b00; s_wready = 2'b00;
        s_bvalid = 2'b01;
        #1;
        vecs++; if (m_bvalid !== 1'b0 || s_bready !== 2'b10) begin errs++;
            $display("FAIL wr1_b_sel got bvalid=%b s_bready=%b exp 0/10", m_bvalid, s_bready); end
        s_bvalid = 2'b10; s_bresp = 4'b0011;
        #1;
        vecs++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00) begin errs++;
            $display("FAIL wr1_b got v=%b r=%b exp 1/00", m_bvalid, m_bresp); end
        step();
        s_bvalid = 2'b00; s_bresp = 4'b0;
        #1;
        vecs++; if (s_bready !== 2'b00 || m_bvalid !== 1'b0) begin errs++;
            $display("FAIL wr1_idle got s_bready=%b m_bvalid=%b exp 00/0", s_bready, m_bvalid); end
        m_bready = 1'b0;
    endtask

    task automatic test_read_priority();
        m_araddr = 32'h8000_0000; m_awaddr = 32'hA000_0000;
        m_arvalid = 1'b1; m_awvalid = 1'b1; m_rready = 1'b1; m_bready = 1'b1;
        step();
        vecs++; if (s_arvalid !== 2'b01 || s_awvalid !== 2'b00 || m_awready !== 1'b0) begin errs++;
            $display("FAIL pri_read_first got ar=%b aw=%b awready=%b exp 01/00/0", s_arvalid, s_awvalid, m_awready); end
        s_arready = 2'b01;
        step();
        m_arvalid = 1'b0; s_arready = 2'b00;
        s_rvalid = 2'b01; s_rdata = {32'h0, 32'h1234_5678};
        #1;
        vecs++; if (m_rdata !== 32'h1234_5678 || m_awready !== 1'b0) begin errs++;
            $display("FAIL pri_rdata got d=%h awready=%b exp 12345678/0", m_rdata, m_awready); end
        step();
        s_rvalid = 2'b00;
        #1;
        vecs++; if (s_awvalid !== 2'b00) begin errs++;
            $display("FAIL pri_idle_gap got=%b exp=00", s_awvalid); end
        step();
        vecs++; if (s_awvalid !== 2'b10 || s_awaddr !== 32'hA000_0000) begin errs++;
            $display("FAIL pri_write got aw=%b a=%h exp 10/a0000000", s_awvalid, s_awaddr); end
        s_awready = 2'b10; m_wvalid = 1'b1; s_wready = 2'b10;
        step();
        m_awvalid = 1'b0; m_wvalid = 1'b0; s_awready = 2'b00; s_wready = 2'b00; s_bvalid = 2'b10;
        #1;
        vecs++; if (m_bvalid !== 1'b1) begin errs++;
            $display("FAIL pri_bvalid got=%b exp=1", m_bvalid); end
        step();
        s_bvalid = 2'b00; m_rready = 1'b0; m_bready = 1'b0;
    endtask

    task automatic test_decerr();
        m_araddr = 32'h1000_0000; m_arvalid = 1'b1; m_rready = 1'b0;
        step();
        vecs++; if (m_arready !== 1'b1 || s_arvalid !== 2'b00 || m_rvalid !== 1'b0) begin errs++;
            $display("FAIL derr_ar got arready=%b s_ar=%b rvalid=%b exp 1/00/0", m_arready, s_arvalid, m_rvalid); end
        step();
        m_arvalid = 1'b0;
        #1;
        vecs++; if (m_arready !== 1'b0 || m_rvalid !== 1'b1 || m_rdata !== 32'h0 || m_rresp !== 2'b11) begin errs++;
            $display("FAIL derr_r got ar=%b v=%b d=%h r=%b exp 0/1/0/11", m_arready, m_rvalid, m_rdata, m_rresp); end
        step();
        vecs++; if (m_rvalid !== 1'b1 || m_rresp !== 2'b11) begin errs++;
            $display("FAIL derr_r_hold got v=%b r=%b exp 1/11", m_rvalid, m_rresp); end
        m_rready = 1'b1;
        step();
        m_rready = 1'b0;
        #1;
        vecs++; if (m_rvalid !== 1'b0) begin errs++;
            $display("FAIL derr_r_done got=%b exp=0", m_rvalid); end
        m_awaddr = 32'h0; m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
        step();
        vecs++; if (m_awready !== 1'b1 || m_wready !== 1'b1 || m_bvalid !== 1'b0) begin errs++;
            $display("FAIL derr_aw_w got aw=%b w=%b b=%b exp 1/1/0", m_awready, m_wready, m_bvalid); end
        vecs++; if (s_awvalid !== 2'b00 || s_wvalid !== 2'b00) begin errs++;
            $display("FAIL derr_slaves got aw=%b w=%b exp 00/00", s_awvalid, s_wvalid); end
        step();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        #1;
        vecs++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b11) begin errs++;
            $display("FAIL derr_b got v=%b r=%b exp 1/11", m_bvalid, m_bresp); end
        step();
        vecs++; if (m_bvalid !== 1'b0) begin errs++;
            $display("FAIL derr_b_done got=%b exp=0", m_bvalid); end
        m_bready = 1'b0;
    endtask

    task automatic test_rready_stall();
        m_araddr = 32'h8000_0004; m_arvalid = 1'b1; m_rready = 1'b0;
        step();
        s_arready = 2'b01;
        step();
        m_araddr = 32'h8000_0100; s_arready = 2'b01;
        s_rvalid = 2'b01; s_rdata = {32'h0, 32'hCAFE_F00D};
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++; if (m_rvalid !== 1'b1 || m_rdata !== 32'hCAFE_F00D) begin errs++;
                $display("FAIL stall_r cyc%0d got v=%b d=%h exp 1/cafef00d", i, m_rvalid, m_rdata); end
            vecs++; if (m_arready !== 1'b0 || s_arvalid !== 2'b00 || s_araddr !== 32'h8000_0004) begin errs++;
                $display("FAIL stall_no_ar cyc%0d got rdy=%b v=%b a=%h exp 0/00/80000004", i, m_arready, s_arvalid, s_araddr); end
            step();
        end
        m_rready = 1'b1; m_arvalid = 1'b0; s_arready = 2'b00;
        step();
        s_rvalid = 2'b00; m_rready = 1'b0;
        #1;
        vecs++; if (m_rvalid !== 1'b0 || s_rready !== 2'b00) begin errs++;
            $display("FAIL stall_done got v=%b rr=%b exp 0/00", m_rvalid, s_rready); end
    endtask

    task automatic test_reset_mid_write();
        m_awaddr = 32'h8000_0040; m_awvalid = 1'b1;
        step();
        s_awready = 2'b01;
        step();
        m_awvalid = 1'b0; s_awready = 2'b00;
        m_wvalid = 1'b1; m_wdata = 32'h77; rst = 1'b1;
        step();
        vecs++; if ({m_arready, m_rvalid, m_awready, m_wready, m_bvalid} !== 5'b0) begin errs++;
            $display("FAIL rstw_m_hs got=%b exp=00000", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}); end
        vecs++; if ({s_arvalid, s_awvalid, s_wvalid, s_bready} !== 8'b0 || s_awaddr !== 32'h0) begin errs++;
            $display("FAIL rstw_s got hs=%b a=%h exp 0/0", {s_arvalid, s_awvalid, s_wvalid, s_bready}, s_awaddr); end
        rst = 1'b0; m_wvalid = 1'b0; m_wdata = 32'h0;
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1; m_rready = 1'b1;
        step();
        vecs++; if (s_arvalid !== 2'b01 || s_wvalid !== 2'b00) begin errs++;
            $display("FAIL rstw_rd_ar got ar=%b w=%b exp 01/00", s_arvalid, s_wvalid); end
        s_arready = 2'b01;
        step();
        m_arvalid = 1'b0; s_arready = 2'b00;
        s_rvalid = 2'b01; s_rdata = {32'h0, 32'h0BAD_F00D};
        #1;
        vecs++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0BAD_F00D || m_rresp !== 2'b00) begin errs++;
            $display("FAIL rstw_rd_r got v=%b d=%h r=%b exp 1/0badf00d/00", m_rvalid, m_rdata, m_rresp); end
        step();
        s_rvalid = 2'b00; m_rready = 1'b0;
        #1;
        vecs++; if (m_rvalid !== 1'b0) begin errs++;
            $display("FAIL rstw_rd_done got=%b exp=0", m_rvalid); end
    endtask

    initial begin
        test_reset();
        test_read_s0();
        test_write_w_first();
        test_read_priority();
        test_decerr();
        test_rready_stall();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
